// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// mux_scan_ctrl : walks a 16:1 mux select, settles, samples into a 16-bit word
// Rev 1.0
// ============================================================================
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mux_out,
    input  logic        data_ready,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        data_valid,
    output logic [15:0] data_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] C_SEL_LAST    = 4'd15;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] dout_q, dout_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= 4'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 16'h0000;
            dout_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    sel_d    = 4'd0;
                    cnt_d    = 4'd0;
                    shadow_d = 16'h0000;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                shadow_d[sel_q] = mux_out;
                if (sel_q == C_SEL_LAST) begin
                    // Bit 15 bypasses the shadow so the word lands in one edge
                    dout_d  = {mux_out, shadow_q[14:0]};
                    sel_d   = 4'd0;
                    state_d = ST_HOLD;
                end else begin
                    sel_d   = sel_q + 4'd1;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end
            end
            ST_HOLD: begin
                if (data_ready) begin
                    if (start) begin
                        state_d  = ST_SETTLE;
                        sel_d    = 4'd0;
                        cnt_d    = 4'd0;
                        shadow_d = 16'h0000;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sel        = sel_q;
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign data_valid = (state_q == ST_HOLD);
    assign data_out   = dout_q;

endmodule
`default_nettype wire
